// File: rtl/chain_reader.sv
// chain_reader: dequeue side of the packet buffer. Picks the highest-priority
// non-empty queue of the requested port and fetches the packet head. It then
// walks the block chain, issuing one SRAM word read per cycle, and releases
// each block once its successor link is known.
//
// state | meaning
// IDLE  | waiting for rea; priority scan of the requested port
// HEAD  | head lookup outstanding (head_req held until head_valid)
// READ  | one SRAM word read per cycle from {blk, offset}
// LINK  | successor lookup outstanding (next_req held until next_valid)
// DONE  | pop_done pulse with the completed queue id
//
// free_en/free_blk are registered. The release of a block therefore lands one
// cycle after the event that frees it: in DONE after the last read, in the
// first READ cycle of the successor block after a link, and in DONE for a
// zero-size packet. A release never overlaps a read of the same block.
module chain_reader #(
  parameter  int PORTS     = 16,
  parameter  int PRIOS     = 8,
  parameter  int BLK_W     = 11,
  parameter  int BLK_WORDS = 8,
  localparam int PORT_W    = $clog2(PORTS),
  localparam int PRIO_W    = $clog2(PRIOS),
  localparam int QID_W     = PORT_W + PRIO_W,
  localparam int OFF_W     = $clog2(BLK_WORDS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rea,
  input  logic [PORT_W-1:0]        out_port,
  input  logic [PORTS*PRIOS-1:0]   queue_nonempty,
  output logic                     busy,
  output logic                     rea_err,
  output logic                     head_req,
  output logic [QID_W-1:0]         head_qid,
  input  logic                     head_valid,
  input  logic [BLK_W-1:0]         head_blk,
  input  logic [7:0]               head_size,
  output logic                     next_req,
  output logic [BLK_W-1:0]         next_cur,
  input  logic                     next_valid,
  input  logic [BLK_W-1:0]         next_blk,
  output logic                     sram_rd_en,
  output logic [BLK_W+OFF_W-1:0]   sram_rd_addr,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic                     free_en,
  output logic [BLK_W-1:0]         free_blk,
  output logic                     pop_done,
  output logic [QID_W-1:0]         pop_qid
);

  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(BLK_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HEAD = 3'd1,
    READ = 3'd2,
    LINK = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [QID_W-1:0]   qid_q;
  logic [BLK_W-1:0]   blk_q;
  logic [OFF_W-1:0]   off_q;
  logic [8:0]         words_left_q;
  logic               first_q;
  logic               rea_err_q;
  logic               free_en_q;
  logic [BLK_W-1:0]   free_blk_q;

  logic [PRIOS-1:0]   port_bits;
  logic               sel_hit;
  logic [PRIO_W-1:0]  sel_prio;
  logic               last_word;

  assign last_word = (words_left_q == 9'd1);
  assign busy      = (state_q != IDLE);
  assign rea_err   = rea_err_q;
  assign free_en   = free_en_q;
  assign free_blk  = free_blk_q;

  // Highest set priority bit of the requested port; later (higher) bits win.
  always_comb begin
    port_bits = queue_nonempty[int'(out_port) * PRIOS +: PRIOS];
    sel_hit   = 1'b0;
    sel_prio  = '0;
    for (int i = 0; i < PRIOS; i++) begin
      if (port_bits[i]) begin
        sel_hit  = 1'b1;
        sel_prio = PRIO_W'(i);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_d      = state_q;
    head_req     = 1'b0;
    head_qid     = '0;
    next_req     = 1'b0;
    next_cur     = '0;
    sram_rd_en   = 1'b0;
    sram_rd_addr = '0;
    out_sop      = 1'b0;
    out_eop      = 1'b0;
    pop_done     = 1'b0;
    pop_qid      = '0;
    case (state_q)
      IDLE: begin
        if (rea && sel_hit) begin
          state_d = HEAD;
        end
      end
      HEAD: begin
        head_req = 1'b1;
        head_qid = qid_q;
        if (head_valid) begin
          state_d = (head_size == 8'd0) ? DONE : READ;
        end
      end
      READ: begin
        sram_rd_en   = 1'b1;
        sram_rd_addr = {blk_q, off_q};
        out_sop      = first_q;
        out_eop      = last_word;
        if (last_word) begin
          state_d = DONE;
        end else if (off_q == OFF_LAST) begin
          state_d = LINK;
        end
      end
      LINK: begin
        next_req = 1'b1;
        next_cur = blk_q;
        if (next_valid) begin
          state_d = READ;
        end
      end
      DONE: begin
        pop_done = 1'b1;
        pop_qid  = qid_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: queue id, block/offset walk, word countdown and release pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qid_q        <= '0;
      blk_q        <= '0;
      off_q        <= '0;
      words_left_q <= '0;
      first_q      <= 1'b0;
      rea_err_q    <= 1'b0;
      free_en_q    <= 1'b0;
      free_blk_q   <= '0;
    end else begin
      rea_err_q  <= 1'b0;
      free_en_q  <= 1'b0;
      free_blk_q <= '0;
      case (state_q)
        IDLE: begin
          if (rea) begin
            if (sel_hit) begin
              qid_q <= {out_port, sel_prio};
            end else begin
              rea_err_q <= 1'b1;
            end
          end
        end
        HEAD: begin
          if (head_valid) begin
            blk_q        <= head_blk;
            off_q        <= '0;
            words_left_q <= {1'b0, head_size};
            first_q      <= 1'b1;
            if (head_size == 8'd0) begin
              free_en_q  <= 1'b1;
              free_blk_q <= head_blk;
            end
          end
        end
        READ: begin
          off_q        <= off_q + OFF_W'(1);
          words_left_q <= words_left_q - 9'd1;
          first_q      <= 1'b0;
          if (last_word) begin
            free_en_q  <= 1'b1;
            free_blk_q <= blk_q;
          end
        end
        LINK: begin
          if (next_valid) begin
            free_en_q  <= 1'b1;
            free_blk_q <= blk_q;
            blk_q      <= next_blk;
            off_q      <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
